// File: rtl/dcache_bus_responder.sv
// Responder end of the DCache request protocol: queues accepted requests in order
// and replays them onto a single-port synchronous SRAM, returning one data_ok per request.
module dcache_bus_responder #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dcache_req,
  input  logic          dcache_wr,
  input  logic [3:0]    dcache_wstrb,
  input  logic [2:0]    dcache_size,
  input  logic [31:0]   dcache_addr,
  input  logic [31:0]   dcache_wdata,
  output logic          dcache_addr_ok,
  output logic          dcache_data_ok,
  output logic [31:0]   dcache_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  logic          q_wr    [DEPTH];
  logic [3:0]    q_wstrb [DEPTH];
  logic [AW-1:0] q_addr  [DEPTH];
  logic [31:0]   q_wdata [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  state_t        state;
  logic [3:0]    cnt;
  logic          is_write;

  logic full, empty, push, pop;

  // Size and sub-word address bits are the initiator's concern; upper bits wrap.
  logic unused_bits;
  assign unused_bits = ^{dcache_size, dcache_addr[1:0], dcache_addr[31:AW+2]};

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign dcache_addr_ok = dcache_req && !full && !reset;
  assign push = dcache_addr_ok;
  assign pop  = (state == IDLE) && !empty;

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pop) begin
      mem_en    = 1'b1;
      mem_wen   = q_wr[head] ? q_wstrb[head] : 4'b0000;
      mem_addr  = q_addr[head];
      mem_wdata = q_wdata[head];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[tail]    <= dcache_wr;
      q_wstrb[tail] <= dcache_wstrb;
      q_addr[tail]  <= dcache_addr[AW+1:2];
      q_wdata[tail] <= dcache_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      state          <= IDLE;
      cnt            <= '0;
      is_write       <= 1'b0;
      dcache_data_ok <= 1'b0;
      dcache_rdata   <= '0;
    end else begin
      dcache_data_ok <= 1'b0;

      if (push) tail <= tail + 1'b1;

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (!empty) begin
            head     <= head + 1'b1;
            cnt      <= 4'(LATENCY);
            is_write <= q_wr[head];
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            dcache_rdata   <= is_write ? '0 : mem_rdata;
            dcache_data_ok <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcache_bus_responder.md
Name: dcache_bus_responder

Overview:
- Responder (slave) end of the execute-stage DCache request protocol (req/wr/wstrb/size/addr/wdata with addr_ok/data_ok/rdata).
- Accepts requests into an in-order pending queue and serialises them onto a synchronous single-port SRAM-style memory port.
- Returns one data_ok pulse per accepted request, in acceptance order, with a parameterised extra memory latency.
- Serves as the uncached/backing-store responder behind the AGU and as the bench target for load/store verification.

Parameters:
DEPTH, 4, pending-request queue entries; power of two, >= 2.
AW, 10, memory word-address width.
LATENCY, 0, extra wait cycles between memory issue and response capture; range 0..15.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
dcache_req  input  1  request valid
dcache_wr  input  1  1 = write, 0 = read
dcache_wstrb  input  4  byte write strobes
dcache_size  input  3  0 = byte, 1 = half, 2 = word; >2 treated as word
dcache_addr  input  32  byte address
dcache_wdata  input  32  write data
dcache_addr_ok  output  1  request accepted this cycle
dcache_data_ok  output  1  response valid, one-cycle pulse
dcache_rdata  output  32  read data, valid with data_ok
mem_en  output  1  memory access strobe
mem_wen  output  4  memory byte write enables
mem_addr  output  AW  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data; valid the cycle after mem_en, held until the next mem_en

Behaviour:
- Reset (asynchronous, active-high): queue empty; FSM in IDLE; counter 0.
  - While reset is high: data_ok=0, rdata=0, addr_ok=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- Acceptance:
  - addr_ok = dcache_req && !full, combinational. It depends on the registered count only, never on a same-cycle pop.
  - A handshake is req && addr_ok. The entry {wr, wstrb, addr[AW+1:2], wdata} is written at the tail at the clock edge.
- Address mapping:
  - Word address = dcache_addr[AW+1:2]. Upper bits are ignored (wrap-around).
  - addr[1:0] and size are not used for memory access. Reads always return the full aligned word; byte/half extraction is the initiator's job.
- Write enables: on write, mem_wen = stored wstrb. A write with wstrb=0 still issues mem_en and still returns data_ok. On read, mem_wen=0.
- Queue: circular, head/tail pointers plus count of width log2(DEPTH)+1.
  - Simultaneous push and pop leaves count unchanged.
  - Push when full is impossible by construction.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT.
  - IDLE with queue non-empty: mem_en=1 and mem_addr/mem_wen/mem_wdata driven combinationally from the head. Pop head, load cnt=LATENCY, latch is_write, go to WAIT.
  - IDLE with queue empty: mem_en=0, other mem outputs 0.
  - WAIT with cnt!=0: cnt decrements.
  - WAIT with cnt==0: register rdata = is_write ? 0 : mem_rdata, set data_ok=1 for the next cycle, go to IDLE.
- data_ok is registered and is high for exactly one cycle per request.
- Latency: request accepted at the edge ending cycle t.
  - mem_en is high in cycle t+1.
  - data_ok is high in cycle t+3+LATENCY.
  - The next queued request's mem_en may coincide with the previous data_ok cycle.
  - Sustained throughput is one request per LATENCY+2 cycles.
- Ordering: responses are strictly in acceptance order; reads and writes are never reordered.
  - A read following a write to the same word returns the written data.
- No flush input: once accepted, every request completes.
- Reset asserted mid-operation discards all queued and in-flight requests; no data_ok is produced for them.

Test Plan:
- Single read: memory word 0x10 = 0xDEADBEEF, LATENCY=0, read addr 0x40 accepted in cycle 0 -> mem_en and mem_addr=0x10 in cycle 1; data_ok with rdata=0xDEADBEEF in cycle 3; single pulse.
- Byte write then read: write addr 0x42, wstrb=0100, wdata=0x00AB0000 over word 0x11223344, then read 0x40 -> mem_wen=0100; write data_ok with rdata=0; read returns 0x11AB3344.
- Queue full: DEPTH=4, LATENCY=3, req held high for 8 reads -> addr_ok drops after 5 acceptances (4 queued + 1 in flight); resumes when a slot frees; 8 data_ok pulses in order, spaced 5 cycles apart.
- Back-to-back throughput: LATENCY=0, 6 reads of distinct words -> mem_en every 2nd cycle; data_ok every 2nd cycle; rdata matches each word in order.
- Address wrap: AW=10, read 0x1000_0040 -> mem_addr=0x010; same data as address 0x40.
- Reset mid-flight: 3 reads accepted, reset asserted asynchronously in the WAIT state -> data_ok, rdata and mem_en go 0 immediately; after release, no stale data_ok; a new read completes normally.
